// File: rtl/mem_copy_engine.sv
// Block-copy client for one port of the shared memory: reads LEN words from SRC,
// buffers the returned data in a small FIFO and writes it back out starting at DST.
module mem_copy_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_avalid,
  input  logic                  r_aready,
  input  logic                  r_dvalid,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  input  logic                  w_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int FW = PW + 1;

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [CW-1:0]         len_q, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [FW-1:0]         inflight_q, inflight_d, count_q, count_d, remain;
  logic [PW-1:0]         wptr_q, rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic                  busy_q, done_q, r_avalid_q, r_avalid_d, w_valid_q, w_valid_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic                  r_acc, push, pop;

  assign busy     = busy_q;
  assign done     = done_q;
  assign r_addr   = r_addr_q;
  assign r_avalid = r_avalid_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;
  assign w_valid  = w_valid_q;

  always_comb begin
    r_acc      = r_avalid_q && r_aready;
    // Data with nothing outstanding is stale (e.g. from before a reset) and dropped.
    push       = r_dvalid && (inflight_q != '0);
    pop        = w_valid_q && w_ready;
    rd_cnt_d   = rd_cnt_q + CW'(r_acc);
    wr_cnt_d   = wr_cnt_q + CW'(pop);
    inflight_d = inflight_q + FW'(r_acc) - FW'(push);
    count_d    = count_q + FW'(push) - FW'(pop);
    rptr_d     = rptr_q + PW'(pop);
    remain     = count_q - FW'(pop);
    r_addr_d   = src_q + rd_cnt_d[ADDR_WIDTH-1:0];
    w_addr_d   = dst_q + wr_cnt_d[ADDR_WIDTH-1:0];
    // A pending read request already satisfied the credit check when it was raised.
    r_avalid_d = (r_avalid_q && !r_aready) ||
                 ((rd_cnt_d < len_q) &&
                  ((int'(inflight_d) + int'(count_d)) < FIFO_DEPTH));
    w_valid_d  = (w_valid_q && !w_ready) || (count_d != '0);
    // When the FIFO drains to empty this cycle, the new head is the word arriving now.
    if (w_valid_q && !w_ready)
      w_data_d = w_data_q;
    else if (remain == '0)
      w_data_d = r_data;
    else
      w_data_d = fifo_q[rptr_d];
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wptr_q] <= r_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      r_avalid_q <= 1'b0;
      r_addr_q   <= '0;
      w_valid_q  <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            src_q    <= src;
            dst_q    <= dst;
            len_q    <= len;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            r_addr_q <= src;
            w_addr_q <= dst;
            busy_q   <= 1'b1;
            if (len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= COPY;
            end
          end
        end
        COPY: begin
          rd_cnt_q   <= rd_cnt_d;
          wr_cnt_q   <= wr_cnt_d;
          inflight_q <= inflight_d;
          count_q    <= count_d;
          wptr_q     <= wptr_q + PW'(push);
          rptr_q     <= rptr_d;
          r_avalid_q <= r_avalid_d;
          r_addr_q   <= r_addr_d;
          w_valid_q  <= w_valid_d;
          w_addr_q   <= w_addr_d;
          w_data_q   <= w_data_d;
          if (wr_cnt_d == len_q) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            r_avalid_q <= 1'b0;
            w_valid_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
